// File: rtl/bus_grant_arbiter_pkg.sv
// Shared definitions for the 68000-side bus arbiter: state encodings,
// default timing parameters and Pi status register bit positions.
package bus_grant_arbiter_pkg;

  localparam int unsigned DEF_SYNC_STAGES    = 2;
  localparam logic [7:0]  DEF_GRANT_TIMEOUT  = 8'd64;
  localparam logic [1:0]  DEF_RECOVER_CYCLES = 2'd1;

  localparam int unsigned GRANT_COUNT_W = 16;

  typedef enum logic [2:0] {
    ARB_IDLE     = 3'd0,
    ARB_WAIT_END = 3'd1,
    ARB_GRANT    = 3'd2,
    ARB_OWNED    = 3'd3,
    ARB_RECOVER  = 3'd4
  } arb_state_e;

  // Bit positions inside PI_REG_STATUS
  localparam int unsigned PI_REG_STATUS_DMA_OWNS_BIT     = 0;
  localparam int unsigned PI_REG_STATUS_TIMEOUT_FLAG_BIT = 1;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for one asynchronous bus signal; resets to the
// inactive level so active-low inputs read as deasserted out of reset.
module sync_bit #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  (* async_reg = "true" *) logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/bus_grant_arbiter.sv
// BR/BG/BGACK arbiter: lets the in-flight Pi bus cycle finish, grants the
// bus to a DMA master, tracks ownership and gates the transaction engine.
module bus_grant_arbiter
  import bus_grant_arbiter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter logic [7:0]  GRANT_TIMEOUT  = DEF_GRANT_TIMEOUT,
  parameter logic [1:0]  RECOVER_CYCLES = DEF_RECOVER_CYCLES
) (
  input  logic                     SYSCLK,
  input  logic                     nRESET,
  input  logic                     MCCLK_FALLING,
  input  logic                     ENABLE,
  input  logic                     nBR_IN,
  input  logic                     nBGACK_IN,
  input  logic                     nAS_IN,
  input  logic                     CYCLE_ACTIVE,
  output logic                     CYCLE_GNT,
  output logic                     BG_DRIVE,
  output logic                     DMA_OWNS,
  output logic [GRANT_COUNT_W-1:0] GRANT_COUNT,
  output logic                     TIMEOUT_FLAG,
  input  logic                     TIMEOUT_CLR
);

  logic nbr_sync, nbgack_sync, nas_sync;

  sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_br (
    .clk(SYSCLK), .rst_n(nRESET), .d(nBR_IN), .q(nbr_sync)
  );
  sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_bgack (
    .clk(SYSCLK), .rst_n(nRESET), .d(nBGACK_IN), .q(nbgack_sync)
  );
  sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_as (
    .clk(SYSCLK), .rst_n(nRESET), .d(nAS_IN), .q(nas_sync)
  );

  logic br, bgack, bus_as, br_pending;

  assign br         = ~nbr_sync;
  assign bgack      = ~nbgack_sync;
  assign bus_as     = ~nas_sync;
  assign br_pending = ENABLE & br;

  arb_state_e state, state_nxt;
  logic [7:0] tmo_cnt, tmo_cnt_nxt;
  logic [1:0] rec_cnt, rec_cnt_nxt;
  logic       grant_done, timeout_hit;

  // Next-state decision, applied only on MC-clock falling edges
  always_comb begin
    state_nxt   = state;
    tmo_cnt_nxt = tmo_cnt;
    rec_cnt_nxt = rec_cnt;
    grant_done  = 1'b0;
    timeout_hit = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (br_pending) state_nxt = CYCLE_ACTIVE ? ARB_WAIT_END : ARB_GRANT;
      end
      ARB_WAIT_END: begin
        if (!br_pending)                  state_nxt = ARB_IDLE;
        else if (!CYCLE_ACTIVE && !bus_as) state_nxt = ARB_GRANT;
      end
      ARB_GRANT: begin
        tmo_cnt_nxt = tmo_cnt + 8'd1;
        if (bgack && !bus_as) begin
          state_nxt  = ARB_OWNED;
          grant_done = 1'b1;
        end else if (!br && !bgack) begin
          state_nxt = ARB_IDLE;
        end else if (tmo_cnt_nxt == GRANT_TIMEOUT) begin
          state_nxt   = ARB_IDLE;
          timeout_hit = 1'b1;
        end
        if (state_nxt != ARB_GRANT) tmo_cnt_nxt = 8'd0;
      end
      ARB_OWNED: begin
        if (!bgack) state_nxt = ARB_RECOVER;
      end
      ARB_RECOVER: begin
        rec_cnt_nxt = rec_cnt + 2'd1;
        if (rec_cnt_nxt == RECOVER_CYCLES) begin
          rec_cnt_nxt = 2'd0;
          state_nxt   = br_pending ? ARB_GRANT : ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // The engine must see the request in the very SYSCLK it arrives
  assign CYCLE_GNT = (state == ARB_IDLE) & ~br_pending;

  always_ff @(posedge SYSCLK or negedge nRESET) begin
    if (!nRESET) begin
      state        <= ARB_IDLE;
      tmo_cnt      <= 8'd0;
      rec_cnt      <= 2'd0;
      BG_DRIVE     <= 1'b0;
      DMA_OWNS     <= 1'b0;
      GRANT_COUNT  <= '0;
      TIMEOUT_FLAG <= 1'b0;
    end else begin
      if (MCCLK_FALLING) begin
        state    <= state_nxt;
        tmo_cnt  <= tmo_cnt_nxt;
        rec_cnt  <= rec_cnt_nxt;
        BG_DRIVE <= (state_nxt == ARB_GRANT);
        DMA_OWNS <= (state_nxt == ARB_OWNED);
        if (grant_done) GRANT_COUNT <= GRANT_COUNT + GRANT_COUNT_W'(1);
      end
      // A timeout landing with a clear pulse keeps the flag set
      if (MCCLK_FALLING && timeout_hit) TIMEOUT_FLAG <= 1'b1;
      else if (TIMEOUT_CLR)             TIMEOUT_FLAG <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_grant_arbiter.sv
// Scoreboard bench for bus_grant_arbiter: a behavioural model queues the
// expected outputs each SYSCLK and a monitor compares them on the falling edge.
module tb_bus_grant_arbiter;

  logic        SYSCLK = 1'b0;
  logic        nRESET = 1'b0;
  logic        MCCLK_FALLING = 1'b0;
  logic        ENABLE = 1'b1;
  logic        nBR_IN = 1'b1;
  logic        nBGACK_IN = 1'b1;
  logic        nAS_IN = 1'b1;
  logic        CYCLE_ACTIVE = 1'b0;
  logic        CYCLE_GNT;
  logic        BG_DRIVE;
  logic        DMA_OWNS;
  logic [15:0] GRANT_COUNT;
  logic        TIMEOUT_FLAG;
  logic        TIMEOUT_CLR = 1'b0;

  bus_grant_arbiter dut (
    .SYSCLK(SYSCLK), .nRESET(nRESET), .MCCLK_FALLING(MCCLK_FALLING),
    .ENABLE(ENABLE), .nBR_IN(nBR_IN), .nBGACK_IN(nBGACK_IN), .nAS_IN(nAS_IN),
    .CYCLE_ACTIVE(CYCLE_ACTIVE), .CYCLE_GNT(CYCLE_GNT), .BG_DRIVE(BG_DRIVE),
    .DMA_OWNS(DMA_OWNS), .GRANT_COUNT(GRANT_COUNT), .TIMEOUT_FLAG(TIMEOUT_FLAG),
    .TIMEOUT_CLR(TIMEOUT_CLR)
  );

  always #5 SYSCLK = ~SYSCLK;

  typedef struct packed {
    logic        gnt;
    logic        bg;
    logic        dma;
    logic [15:0] cnt;
    logic        flag;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   mc_edges = 0;
  bit   do_preload = 1'b0;

  // One MC falling-edge pulse every fourth SYSCLK
  initial begin
    int ph = 0;
    forever begin
      @(posedge SYSCLK);
      if (MCCLK_FALLING) mc_edges++;
      #1;
      MCCLK_FALLING = (ph == 3);
      ph = (ph + 1) % 4;
    end
  end

  // Reference model: bus phases as the arbiter is supposed to walk them
  localparam int P_IDLE = 0, P_WAIT = 1, P_GRANT = 2, P_OWNED = 3, P_RECOV = 4;
  initial begin
    int          phase = P_IDLE;
    int          grant_edges = 0;
    int          recov_edges = 0;
    logic [15:0] cnt = 16'd0;
    logic        flag = 1'b0;
    logic [1:0]  br_s = 2'b00, ack_s = 2'b00, as_s = 2'b00;
    bit          forcing = 1'b0;
    forever begin
      @(posedge SYSCLK);
      if (!nRESET) begin
        phase = P_IDLE; grant_edges = 0; recov_edges = 0; cnt = 16'd0; flag = 1'b0;
        br_s = 2'b00; ack_s = 2'b00; as_s = 2'b00;
      end else begin
        logic br, ack, as_v, pend, tmo;
        br = br_s[1]; ack = ack_s[1]; as_v = as_s[1];
        pend = ENABLE && br;
        tmo = 1'b0;
        if (MCCLK_FALLING) begin
          case (phase)
            P_IDLE: if (pend) phase = CYCLE_ACTIVE ? P_WAIT : P_GRANT;
            P_WAIT: begin
              if (!pend) phase = P_IDLE;
              else if (!CYCLE_ACTIVE && !as_v) phase = P_GRANT;
            end
            P_GRANT: begin
              grant_edges++;
              if (ack && !as_v) begin
                phase = P_OWNED;
                cnt = cnt + 16'd1;
              end else if (!br && !ack) begin
                phase = P_IDLE;
              end else if (grant_edges == 64) begin
                phase = P_IDLE;
                tmo = 1'b1;
              end
              if (phase != P_GRANT) grant_edges = 0;
            end
            P_OWNED: if (!ack) phase = P_RECOV;
            default: begin
              recov_edges++;
              if (recov_edges == 1) begin
                recov_edges = 0;
                phase = pend ? P_GRANT : P_IDLE;
              end
            end
          endcase
        end
        if (tmo) flag = 1'b1;
        else if (TIMEOUT_CLR) flag = 1'b0;
        br_s  = {br_s[0], ~nBR_IN};
        ack_s = {ack_s[0], ~nBGACK_IN};
        as_s  = {as_s[0], ~nAS_IN};
      end
      #3;
      if (!nRESET) begin
        phase = P_IDLE; grant_edges = 0; recov_edges = 0; cnt = 16'd0; flag = 1'b0;
        br_s = 2'b00; ack_s = 2'b00; as_s = 2'b00;
      end
      if (forcing) begin
        release dut.GRANT_COUNT;
        forcing = 1'b0;
      end
      if (do_preload) begin
        force dut.GRANT_COUNT = 16'hFFFF;
        cnt = 16'hFFFF;
        do_preload = 1'b0;
        forcing = 1'b1;
      end
      exp_q.push_back('{gnt: (phase == P_IDLE) && !(ENABLE && br_s[1]),
                        bg: (phase == P_GRANT), dma: (phase == P_OWNED),
                        cnt: cnt, flag: flag});
    end
  end

  function automatic void check(string name, logic [15:0] act, logic [15:0] req);
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endfunction

  // Monitor: compare the DUT against the next queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge SYSCLK);
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_empty at %0t: got no expectation expected one", $time);
      end else begin
        e = exp_q.pop_front();
        check("CYCLE_GNT",    16'(CYCLE_GNT),    16'(e.gnt));
        check("BG_DRIVE",     16'(BG_DRIVE),     16'(e.bg));
        check("DMA_OWNS",     16'(DMA_OWNS),     16'(e.dma));
        check("GRANT_COUNT",  GRANT_COUNT,       e.cnt);
        check("TIMEOUT_FLAG", 16'(TIMEOUT_FLAG), 16'(e.flag));
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge SYSCLK);
    #2;
  endtask

  task automatic mc(int n);
    int target;
    target = mc_edges + n;
    while (mc_edges < target) cyc(1);
  endtask

  task automatic idle_bus();
    nBR_IN = 1'b1; nBGACK_IN = 1'b1; nAS_IN = 1'b1;
    CYCLE_ACTIVE = 1'b0; ENABLE = 1'b1; TIMEOUT_CLR = 1'b0;
    mc(4);
  endtask

  task automatic full_grant();
    nBR_IN = 1'b0;
    mc(3);
    nBGACK_IN = 1'b0;
    nAS_IN = 1'b1;
    mc(3);
    nBR_IN = 1'b1;
    nBGACK_IN = 1'b1;
    mc(3);
  endtask

  initial begin
    cyc(3);
    nRESET = 1'b1;
    mc(2);

    // Basic grant, ownership and recovery
    full_grant();
    idle_bus();

    // Request while the engine is mid-cycle
    CYCLE_ACTIVE = 1'b1; nAS_IN = 1'b0; nBR_IN = 1'b0;
    mc(5);
    CYCLE_ACTIVE = 1'b0;
    mc(2);
    nAS_IN = 1'b1;
    mc(2);
    nBGACK_IN = 1'b0;
    mc(2);
    idle_bus();

    // Grant timeout, then clear
    nBR_IN = 1'b0;
    mc(66);
    nBR_IN = 1'b1;
    mc(3);
    TIMEOUT_CLR = 1'b1;
    cyc(1);
    TIMEOUT_CLR = 1'b0;
    mc(2);

    // Timeout coinciding with a held clear: set wins for that edge
    nBR_IN = 1'b0;
    TIMEOUT_CLR = 1'b1;
    mc(67);
    nBR_IN = 1'b1;
    cyc(2);
    TIMEOUT_CLR = 1'b0;
    idle_bus();

    // Request withdrawn during GRANT with no acknowledge
    nBR_IN = 1'b0;
    mc(3);
    nBR_IN = 1'b1;
    mc(3);

    // ENABLE=0 ignores requests but never revokes an owner
    ENABLE = 1'b0;
    nBR_IN = 1'b0;
    mc(3);
    ENABLE = 1'b1;
    mc(3);
    nBGACK_IN = 1'b0;
    mc(2);
    ENABLE = 1'b0;
    mc(2);
    nBGACK_IN = 1'b1;
    mc(3);
    idle_bus();

    // Grant counter wrap
    do_preload = 1'b1;
    cyc(3);
    full_grant();
    idle_bus();

    // Asynchronous reset while a DMA master owns the bus
    nBR_IN = 1'b0;
    mc(3);
    nBGACK_IN = 1'b0;
    mc(3);
    nRESET = 1'b0;
    cyc(3);
    nBR_IN = 1'b1;
    nBGACK_IN = 1'b1;
    nRESET = 1'b1;
    mc(3);

    // Randomised traffic with a reactive DMA master
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) < 30) nBR_IN = ~nBR_IN;
      CYCLE_ACTIVE = ($urandom_range(0, 99) < 30);
      nAS_IN = 1'(!(CYCLE_ACTIVE || ($urandom_range(0, 9) == 0)));
      ENABLE = ($urandom_range(0, 99) < 90);
      if (BG_DRIVE && nBGACK_IN && ($urandom_range(0, 1) == 1)) begin
        nBGACK_IN = 1'b0;
        nAS_IN = 1'b1;
      end else if (!nBGACK_IN && ($urandom_range(0, 99) < 25)) begin
        nBGACK_IN = 1'b1;
      end
      TIMEOUT_CLR = ($urandom_range(0, 99) < 5);
      cyc(1);
      TIMEOUT_CLR = 1'b0;
      mc(1);
    end
    idle_bus();

    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
